// File: rtl/i2c_pkg.sv
// i2c_pkg: shared states, status codes and line decode for the single-byte I2C initiator
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE} state_t;
    localparam logic [1:0] STS_OK    = 2'b00;
    localparam logic [1:0] STS_BUSY  = 2'b01;
    localparam logic [1:0] STS_ANACK = 2'b10;
    localparam logic [1:0] STS_DNACK = 2'b11;
    // returns {scl, sda_oe}; b is the bit to place on SDA (1 releases the line)
    function automatic logic [1:0] line_levels(state_t s, logic [1:0] q, logic b);
        case (s)
            START:              return {q != 2'd3, q != 2'd0};
            ADDR, DATA:         return {q[1], ~b};
            ADDR_ACK, DATA_ACK: return {q[1], 1'b0};
            STOP:               return {q != 2'd0, q != 2'd3};
            default:            return 2'b10;
        endcase
    endfunction
endpackage

// File: rtl/i2c_master_byte_if.sv
// i2c_master_byte_if: register-file request/status and SDA/SCL pad signals
interface i2c_master_byte_if;
    logic       start;
    logic       rw;
    logic [6:0] slave_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic [1:0] i2c_sts;
    logic       i2c_wr_en;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_i;
    modport master (input start, rw, slave_addr, wr_data, sda_i,
                    output rd_data, busy, i2c_sts, i2c_wr_en, scl_o, sda_oe);
    modport slave (output start, rw, slave_addr, wr_data, sda_i,
                   input rd_data, busy, i2c_sts, i2c_wr_en, scl_o, sda_oe);
endinterface

// File: rtl/i2c_qtick.sv
// i2c_qtick: SCL quarter-period divider with synchronous clear and terminal-count tick
module i2c_qtick #(parameter int CLK_DIV = 4) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLK_DIV - 1);
    always_ff @(posedge clk)
        cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-byte 7-bit-address I2C initiator with status write-back strobe
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic clk,
    input logic rst,
    i2c_master_byte_if.master bus
);
    state_t     state, state_n;
    logic       tick, accept, pend, ack, rwl;
    logic [1:0] q, res;
    logic [2:0] n;
    logic [7:0] sh, wd, rx;

    assign accept = state == IDLE && bus.start;
    // read data phase keeps SDA released; otherwise the shift MSB goes out
    assign {bus.scl_o, bus.sda_oe} = line_levels(state, q, (state == DATA && rwl) || sh[7]);

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (.clk(clk), .rst(rst), .clr(accept), .tick(tick));

    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = bus.start ? START : IDLE;
        else if (state == DONE) state_n = IDLE;
        else if (tick && q == 2'd3)
            case (state)
                START:    state_n = ADDR;
                ADDR:     state_n = n == 3'd7 ? ADDR_ACK : ADDR;
                ADDR_ACK: state_n = ack ? STOP : DATA;
                DATA:     state_n = n == 3'd7 ? DATA_ACK : DATA;
                DATA_ACK: state_n = STOP;
                default:  state_n = DONE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            q             <= '0;
            n             <= '0;
            pend          <= 1'b0;
            ack           <= 1'b0;
            rwl           <= 1'b0;
            res           <= STS_OK;
            sh            <= '0;
            wd            <= '0;
            rx            <= '0;
            bus.rd_data   <= '0;
            bus.busy      <= 1'b0;
            bus.i2c_sts   <= STS_OK;
            bus.i2c_wr_en <= 1'b0;
        end else begin
            state         <= state_n;
            pend          <= accept;
            bus.i2c_wr_en <= pend;
            if (pend) bus.i2c_sts <= STS_BUSY;
            if (accept) begin
                sh       <= {bus.slave_addr, bus.rw};
                wd       <= bus.wr_data;
                rwl      <= bus.rw;
                res      <= STS_OK;
                q        <= '0;
                n        <= '0;
                bus.busy <= 1'b1;
            end
            if (state == DONE) bus.busy <= 1'b0;
            if (tick && state != IDLE && state != DONE) begin
                q <= q + 1'b1;
                if (q == 2'd2) begin
                    ack <= bus.sda_i;
                    if (state == DATA) rx <= {rx[6:0], bus.sda_i};
                end
                if (q == 2'd3) begin
                    if (state == ADDR || state == DATA) begin
                        sh <= {sh[6:0], 1'b0};
                        n  <= n + 1'b1;
                    end
                    if (state == ADDR_ACK) begin
                        if (ack) res <= STS_ANACK;
                        else sh <= wd;
                    end
                    if (state == DATA_ACK && !rwl && ack) res <= STS_DNACK;
                    if (state == STOP) begin
                        bus.i2c_sts   <= res;
                        bus.i2c_wr_en <= 1'b1;
                        if (rwl && res == STS_OK) bus.rd_data <= rx;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_byte.sv
// tb_i2c_master_byte: directed transfers against a behavioural I2C slave on the pads
module tb_i2c_master_byte;
    logic clk = 1'b0;
    logic rst = 1'b1;
    i2c_master_byte_if bus_if();

    i2c_master_byte #(.CLK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus_if.master));

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          strobes = 0;
    int          rises = 0;
    logic [31:0] cap = '0;
    logic        slave_low = 1'b0;
    logic        p_scl = 1'b1;
    logic        p_sda = 1'b1;
    logic        nack_a = 1'b0;
    logic        nack_d = 1'b0;
    logic        rd_mode = 1'b0;
    logic [7:0]  rd_byte = 8'h00;
    logic        sda_bus;

    assign sda_bus = ~(bus_if.sda_oe | slave_low);
    assign bus_if.sda_i = sda_bus;

    // slave: count SCL rises since START, capture SDA on rises, change SDA after falls
    always @(negedge clk) begin
        p_scl   <= bus_if.scl_o;
        p_sda   <= sda_bus;
        strobes <= strobes + (bus_if.i2c_wr_en ? 1 : 0);
        if (bus_if.scl_o && p_scl && p_sda && !sda_bus) rises <= 0;
        else if (bus_if.scl_o && !p_scl) begin
            rises <= rises + 1;
            cap   <= {cap[30:0], sda_bus};
        end
        if (!bus_if.scl_o && p_scl)
            slave_low <= (rises == 8) ? !nack_a :
                         (rd_mode && rises >= 9 && rises <= 16) ? !rd_byte[16 - rises] :
                         (!rd_mode && rises == 17) ? !nack_d : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [6:0] a, input logic r, input logic [7:0] d,
                       input int plant, input int lat, input logic [1:0] sts, input string tag);
        int c;
        int s0;
        s0 = strobes;
        bus_if.start = 1'b1;
        bus_if.slave_addr = a;
        bus_if.rw = r;
        bus_if.wr_data = d;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk({tag, ".busy_accept"}, 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        chk({tag, ".wr_en_accept"}, 32'(bus_if.i2c_wr_en), 32'd1);
        chk({tag, ".sts_busy"}, 32'(bus_if.i2c_sts), 32'd1);
        c = 1;
        do begin
            @(negedge clk);
            c++;
            if (c == plant) begin
                bus_if.start = 1'b1;
                bus_if.slave_addr = 7'h11;
                bus_if.rw = ~r;
                bus_if.wr_data = ~d;
            end else if (c == plant + 1) bus_if.start = 1'b0;
        end while (!bus_if.i2c_wr_en && c < 600);
        chk({tag, ".latency"}, 32'(c), 32'(lat));
        chk({tag, ".sts_done"}, 32'(bus_if.i2c_sts), 32'(sts));
        @(negedge clk);
        chk({tag, ".busy_after"}, 32'(bus_if.busy), 32'd0);
        chk({tag, ".strobes"}, 32'(strobes - s0), 32'd2);
    endtask

    initial begin
        int s0;
        bus_if.start = 1'b0;
        bus_if.rw = 1'b0;
        bus_if.slave_addr = 7'h00;
        bus_if.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst.scl", 32'(bus_if.scl_o), 32'd1);
        chk("rst.sda_oe", 32'(bus_if.sda_oe), 32'd0);
        chk("rst.busy", 32'(bus_if.busy), 32'd0);
        chk("rst.sts", 32'(bus_if.i2c_sts), 32'd0);
        chk("rst.wr_en", 32'(bus_if.i2c_wr_en), 32'd0);
        chk("rst.rd_data", 32'(bus_if.rd_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(7'h50, 1'b0, 8'hA5, 0, 320, 2'b00, "wr");
        chk("wr.addr_byte", 32'(cap[18:11]), 32'hA0);
        chk("wr.addr_ack", 32'(cap[10]), 32'd0);
        chk("wr.data_byte", 32'(cap[9:2]), 32'hA5);
        chk("wr.data_ack", 32'(cap[1]), 32'd0);
        chk("wr.scl_rises", 32'(rises), 32'd19);
        chk("wr.rd_data", 32'(bus_if.rd_data), 32'h00);

        rd_mode = 1'b1;
        rd_byte = 8'h5A;
        run(7'h3C, 1'b1, 8'h00, 0, 320, 2'b00, "rd");
        chk("rd.rd_data", 32'(bus_if.rd_data), 32'h5A);
        chk("rd.addr_byte", 32'(cap[18:11]), 32'h79);
        chk("rd.bus_byte", 32'(cap[9:2]), 32'h5A);
        chk("rd.master_nack", 32'(cap[1]), 32'd1);

        rd_mode = 1'b0;
        nack_a = 1'b1;
        run(7'h22, 1'b0, 8'h11, 0, 176, 2'b10, "anack");
        chk("anack.scl_rises", 32'(rises), 32'd10);
        chk("anack.addr_byte", 32'(cap[9:2]), 32'h44);
        chk("anack.ack_bit", 32'(cap[1]), 32'd1);
        chk("anack.rd_data", 32'(bus_if.rd_data), 32'h5A);

        nack_a = 1'b0;
        nack_d = 1'b1;
        run(7'h50, 1'b0, 8'hFF, 0, 320, 2'b11, "dnack");
        chk("dnack.data_byte", 32'(cap[9:2]), 32'hFF);
        chk("dnack.ack_bit", 32'(cap[1]), 32'd1);
        chk("dnack.rd_data", 32'(bus_if.rd_data), 32'h5A);

        nack_d = 1'b0;
        run(7'h50, 1'b0, 8'hA5, 50, 320, 2'b00, "ign");
        chk("ign.addr_byte", 32'(cap[18:11]), 32'hA0);
        chk("ign.data_byte", 32'(cap[9:2]), 32'hA5);

        run(7'h2B, 1'b0, 8'h3C, 0, 320, 2'b00, "b2b");
        chk("b2b.addr_byte", 32'(cap[18:11]), 32'h56);
        chk("b2b.data_byte", 32'(cap[9:2]), 32'h3C);

        bus_if.start = 1'b1;
        bus_if.slave_addr = 7'h50;
        bus_if.rw = 1'b0;
        bus_if.wr_data = 8'hA5;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (100) @(negedge clk);
        s0 = strobes;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.scl", 32'(bus_if.scl_o), 32'd1);
        chk("midrst.sda_oe", 32'(bus_if.sda_oe), 32'd0);
        chk("midrst.busy", 32'(bus_if.busy), 32'd0);
        chk("midrst.sts", 32'(bus_if.i2c_sts), 32'd0);
        chk("midrst.rd_data", 32'(bus_if.rd_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst.no_strobe", 32'(strobes - s0), 32'd0);
        chk("midrst.idle_scl", 32'(bus_if.scl_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
